rx_core_tune_sequencer: RTL and testbench

Hop-table controller that programs the `rx_core` tuning inputs: `output_select` and the `ddc1..3_phase_inc` / `duc1..3_phase_inc` words. Software fills a small table of tuning entries through a write port. On `start`, the block steps through entries 0..`last_index`, holding each for a programmable dwell and applying every entry atomically in one clock, with optional looping. It sits between the PS-side register bank and `rx_core`, in the `rx_core` clock domain.

---
 rtl/rx_core_pkg.sv | 32 +++
 rtl/rx_core_tune_sequencer_if.sv | 48 ++++
 rtl/rx_core_tune_sequencer_tune_table.sv | 60 ++++++
 rtl/rx_core_tune_sequencer.sv | 133 +++++++++++++
 tb/tb_rx_core_tune_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_core_pkg.sv
// Shared definitions for the rx_core tuning sequencer.
//   - table write field codes
//   - sequencer state encoding
//   - tune_entry_t: one hop-table entry (5 + 6x16 = 101 bits)
package rx_core_pkg;

    localparam logic [2:0] FLD_OSEL = 3'd0;
    localparam logic [2:0] FLD_DDC1 = 3'd1;
    localparam logic [2:0] FLD_DDC2 = 3'd2;
    localparam logic [2:0] FLD_DDC3 = 3'd3;
    localparam logic [2:0] FLD_DUC1 = 3'd4;
    localparam logic [2:0] FLD_DUC2 = 3'd5;
    localparam logic [2:0] FLD_DUC3 = 3'd6;
    localparam logic [2:0] FLD_NONE = 3'd7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDwell = 2'd2
    } tune_state_e;

    typedef struct packed {
        logic [4:0]  osel;
        logic [15:0] ddc1;
        logic [15:0] ddc2;
        logic [15:0] ddc3;
        logic [15:0] duc1;
        logic [15:0] duc2;
        logic [15:0] duc3;
    } tune_entry_t;

endpackage

// File: rtl/rx_core_tune_sequencer_if.sv
// Bus between the PS-side register bank (master) and the tuning sequencer (slave).
//   cfg_wr_*            : table write port, one write per cycle
//   start/stop/loop_en  : run control pulses and loop enable
//   last_index/dwell    : run parameters, sampled on start
//   output_select, ddc*/duc*_phase_inc, hop_strobe, entry_index, busy : to rx_core
interface rx_core_tune_sequencer_if #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned DWELL_W = 24
);
    logic               cfg_wr_en;
    logic [ADDR_W-1:0]  cfg_wr_addr;
    logic [2:0]         cfg_wr_field;
    logic [15:0]        cfg_wr_data;
    logic               start;
    logic               stop;
    logic               loop_en;
    logic [ADDR_W-1:0]  last_index;
    logic [DWELL_W-1:0] dwell_cycles;

    logic [4:0]         output_select;
    logic [15:0]        ddc1_phase_inc;
    logic [15:0]        ddc2_phase_inc;
    logic [15:0]        ddc3_phase_inc;
    logic [15:0]        duc1_phase_inc;
    logic [15:0]        duc2_phase_inc;
    logic [15:0]        duc3_phase_inc;
    logic               hop_strobe;
    logic [ADDR_W-1:0]  entry_index;
    logic               busy;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_field, cfg_wr_data,
        output start, stop, loop_en, last_index, dwell_cycles,
        input  output_select, ddc1_phase_inc, ddc2_phase_inc, ddc3_phase_inc,
        input  duc1_phase_inc, duc2_phase_inc, duc3_phase_inc,
        input  hop_strobe, entry_index, busy
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_field, cfg_wr_data,
        input  start, stop, loop_en, last_index, dwell_cycles,
        output output_select, ddc1_phase_inc, ddc2_phase_inc, ddc3_phase_inc,
        output duc1_phase_inc, duc2_phase_inc, duc3_phase_inc,
        output hop_strobe, entry_index, busy
    );

endinterface

// File: rtl/rx_core_tune_sequencer_tune_table.sv
// tune_table: DEPTH x 101-bit hop table with per-field writes and a registered
// read port. The read register is the block's tuning output register, so an
// entry is applied to all seven outputs on a single edge.
//   clk_i, rst_ni          : clock, async active-low reset (clears table and read reg)
//   wr_en_i/addr/field/data: field write; field 7 and out-of-range addresses dropped
//   rd_en_i, rd_idx_i      : load entry rd_idx_i into rd_data_o on the next edge
//   rd_data_o              : currently applied entry
module tune_table
    import rx_core_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [2:0]        wr_field_i,
    input  logic [15:0]       wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output tune_entry_t       rd_data_o
);

    tune_entry_t table_q [DEPTH];
    tune_entry_t table_d [DEPTH];
    tune_entry_t rd_q;

    always_comb begin
        table_d = table_q;
        if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
            unique case (wr_field_i)
                FLD_OSEL: table_d[wr_addr_i].osel = wr_data_i[4:0];
                FLD_DDC1: table_d[wr_addr_i].ddc1 = wr_data_i;
                FLD_DDC2: table_d[wr_addr_i].ddc2 = wr_data_i;
                FLD_DDC3: table_d[wr_addr_i].ddc3 = wr_data_i;
                FLD_DUC1: table_d[wr_addr_i].duc1 = wr_data_i;
                FLD_DUC2: table_d[wr_addr_i].duc2 = wr_data_i;
                FLD_DUC3: table_d[wr_addr_i].duc3 = wr_data_i;
                default:  ;
            endcase
        end
    end

    // Read uses table_q, so a write landing on the load edge is seen next visit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            table_q <= '{default: '0};
            rd_q    <= '0;
        end else begin
            table_q <= table_d;
            if (rd_en_i) begin
                rd_q <= table_q[rd_idx_i];
            end
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/rx_core_tune_sequencer.sv
// rx_core_tune_sequencer: hop-table controller driving the rx_core tuning inputs.
// On start it steps entries 0..last_index, applying each entry atomically
// (hop_strobe marks the first cycle) and holding it for max(dwell,1)+1 clocks
// per hop, optionally looping. stop aborts; outputs keep their last values.
//   clock, resetn : datapath clock, async active-low reset
//   bus           : rx_core_tune_sequencer_if.slave (config, control, tuning outputs)
module rx_core_tune_sequencer
    import rx_core_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned DWELL_W = 24
) (
    input logic                     clock,
    input logic                     resetn,
    rx_core_tune_sequencer_if.slave bus
);

    tune_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]  entry_index_q, entry_index_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic               strobe_q, strobe_d;
    logic               load;
    tune_entry_t        applied;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_d        = last_q;
        entry_index_d = entry_index_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        loop_d        = loop_q;
        strobe_d      = 1'b0;
        load          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    dwell_d = bus.dwell_cycles;
                    loop_d  = bus.loop_en;
                    last_d  = (int'(bus.last_index) > DEPTH - 1) ? ADDR_W'(DEPTH - 1)
                                                                  : bus.last_index;
                    idx_d   = '0;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else begin
                    load          = 1'b1;
                    strobe_d      = 1'b1;
                    entry_index_d = idx_q;
                    // dwell of 0 behaves like 1: one DWELL cycle per hop minimum
                    cnt_d   = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (bus.stop) begin
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    if (idx_q != last_q) begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StLoad;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            last_q        <= '0;
            entry_index_q <= '0;
            cnt_q         <= '0;
            dwell_q       <= '0;
            loop_q        <= 1'b0;
            strobe_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            last_q        <= last_d;
            entry_index_q <= entry_index_d;
            cnt_q         <= cnt_d;
            dwell_q       <= dwell_d;
            loop_q        <= loop_d;
            strobe_q      <= strobe_d;
        end
    end

    tune_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_tune_table (
        .clk_i      (clock),
        .rst_ni     (resetn),
        .wr_en_i    (bus.cfg_wr_en),
        .wr_addr_i  (bus.cfg_wr_addr),
        .wr_field_i (bus.cfg_wr_field),
        .wr_data_i  (bus.cfg_wr_data),
        .rd_en_i    (load),
        .rd_idx_i   (idx_q),
        .rd_data_o  (applied)
    );

    assign bus.output_select  = applied.osel;
    assign bus.ddc1_phase_inc = applied.ddc1;
    assign bus.ddc2_phase_inc = applied.ddc2;
    assign bus.ddc3_phase_inc = applied.ddc3;
    assign bus.duc1_phase_inc = applied.duc1;
    assign bus.duc2_phase_inc = applied.duc2;
    assign bus.duc3_phase_inc = applied.duc3;
    assign bus.hop_strobe     = strobe_q;
    assign bus.entry_index    = entry_index_q;
    assign bus.busy           = (state_q != StIdle);

endmodule

// File: tb/tb_rx_core_tune_sequencer.sv
// Scoreboard bench for rx_core_tune_sequencer: directed runs push expected hops
// (cycle, index, entry) into a queue; a negedge monitor pops one per hop_strobe.
module tb_rx_core_tune_sequencer;
    import rx_core_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 24;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    rx_core_tune_sequencer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DWELL_W(DW)) bus ();

    rx_core_tune_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW), .DWELL_W(DW)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int unsigned     cyc;
        logic [AW-1:0]   idx;
        tune_entry_t     ent;
    } exp_t;

    exp_t        exp_q[$];
    tune_entry_t mdl [DEPTH];
    int unsigned cyc      = 0;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic tune_entry_t outs();
        tune_entry_t o;
        o = '{bus.output_select, bus.ddc1_phase_inc, bus.ddc2_phase_inc, bus.ddc3_phase_inc,
              bus.duc1_phase_inc, bus.duc2_phase_inc, bus.duc3_phase_inc};
        return o;
    endfunction

    // Monitor: every strobe must match the oldest expected hop exactly.
    always @(negedge clock) begin
        if (resetn && bus.hop_strobe) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 128'(cyc), 128'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hop_cycle", 128'(cyc), 128'(e.cyc));
                chk("hop_index", 128'(bus.entry_index), 128'(e.idx));
                chk("hop_entry", 128'(outs()), 128'(e.ent));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic void mdl_wr(input int a, input int f, input logic [15:0] d);
        case (f)
            0: mdl[a].osel = d[4:0];
            1: mdl[a].ddc1 = d;
            2: mdl[a].ddc2 = d;
            3: mdl[a].ddc3 = d;
            4: mdl[a].duc1 = d;
            5: mdl[a].duc2 = d;
            6: mdl[a].duc3 = d;
            default: ;
        endcase
    endfunction

    task automatic wr(input int a, input int f, input logic [15:0] d);
        bus.cfg_wr_en    = 1'b1;
        bus.cfg_wr_addr  = AW'(a);
        bus.cfg_wr_field = 3'(f);
        bus.cfg_wr_data  = d;
        tick();
        bus.cfg_wr_en    = 1'b0;
        mdl_wr(a, f, d);
    endtask

    // Start is sampled on the edge e0; first hop appears at e0+1.
    task automatic run(input int d, input int last, input bit lp, output int unsigned e0);
        bus.dwell_cycles = DW'(d);
        bus.last_index   = AW'(last);
        bus.loop_en      = lp;
        bus.start        = 1'b1;
        e0 = cyc + 1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic push(input int unsigned c, input int i);
        exp_t e;
        e.cyc = c;
        e.idx = AW'(i);
        e.ent = mdl[i];
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) tick();
    endtask

    task automatic stop_now();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int n;
        bus.cfg_wr_en = 0; bus.cfg_wr_addr = '0; bus.cfg_wr_field = '0; bus.cfg_wr_data = '0;
        bus.start = 0; bus.stop = 0; bus.loop_en = 0; bus.last_index = '0; bus.dwell_cycles = '0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;

        // Reset state
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        chk("rst_outputs", 128'(outs()), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_strobe", 128'(bus.hop_strobe), 128'(0));
        chk("rst_index", 128'(bus.entry_index), 128'(0));

        // Fill entries 0..2; ddc2 left at 0
        for (int k = 0; k < 3; k++) begin
            wr(k, 0, 16'(k + 1));
            wr(k, 1, 16'((k + 1) << 12));
            for (int f = 3; f < 7; f++) wr(k, f, 16'(f * 16'h1000 + k * 16'h10 + 5));
        end

        // Single pass, dwell 4: hops at e0+1, +6, +11; busy falls 4 cycles later
        run(4, 2, 1'b0, e0);
        for (int k = 0; k < 3; k++) push(e0 + 1 + 5 * k, k);
        n = 0;
        while (bus.busy && n < 100) begin tick(); n++; end
        chk("busy_fall_cycle", 128'(cyc), 128'(e0 + 11 + 4));
        chk("pass_all_hops", 128'(exp_q.size()), 128'(0));
        chk("hold_ddc1", 128'(bus.ddc1_phase_inc), 128'(16'h3000));
        chk("hold_osel", 128'(bus.output_select), 128'(3));

        // Loop: three full laps plus the return to entry 0, then stop mid-dwell
        run(4, 2, 1'b1, e0);
        for (int k = 0; k < 10; k++) push(e0 + 1 + 5 * k, k % 3);
        wait_until(e0 + 46);
        stop_now();
        chk("loop_stop_busy", 128'(bus.busy), 128'(0));
        chk("loop_all_hops", 128'(exp_q.size()), 128'(0));
        repeat (12) tick();
        chk("loop_frozen", 128'(outs()), 128'(mdl[0]));
        chk("loop_frozen_ddc1", 128'(bus.ddc1_phase_inc), 128'(16'h1000));

        // dwell 0: hop every 2 cycles; stop on the edge the counter expires
        run(0, 1, 1'b1, e0);
        for (int k = 0; k < 6; k++) push(e0 + 1 + 2 * k, k % 2);
        wait_until(e0 + 11);
        stop_now();
        chk("d0_stop_busy", 128'(bus.busy), 128'(0));
        repeat (10) tick();
        chk("d0_frozen", 128'(outs()), 128'(mdl[1]));
        chk("d0_frozen_index", 128'(bus.entry_index), 128'(1));
        chk("d0_all_hops", 128'(exp_q.size()), 128'(0));

        // Field-7 write is dropped; write on entry 1's load edge applies next lap
        wr(0, 7, 16'hFFFF);
        run(4, 2, 1'b1, e0);
        for (int k = 0; k < 3; k++) push(e0 + 1 + 5 * k, k);
        wait_until(e0 + 5);
        wr(1, 2, 16'hBEEF);
        for (int k = 3; k < 6; k++) push(e0 + 1 + 5 * k, k % 3);
        chk("beef_model", 128'(mdl[1].ddc2), 128'(16'hBEEF));
        wait_until(e0 + 26);
        stop_now();
        chk("beef_stop_busy", 128'(bus.busy), 128'(0));
        chk("beef_all_hops", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset mid-dwell clears outputs and table
        run(4, 2, 1'b1, e0);
        push(e0 + 1, 0);
        wait_until(e0 + 3);
        chk("pre_rst_hops", 128'(exp_q.size()), 128'(0));
        resetn = 1'b0;
        #1;
        chk("async_rst_outputs", 128'(outs()), 128'(0));
        chk("async_rst_busy", 128'(bus.busy), 128'(0));
        chk("async_rst_index", 128'(bus.entry_index), 128'(0));
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        run(1, 0, 1'b0, e0);
        push(e0 + 1, 0);
        n = 0;
        while (bus.busy && n < 100) begin tick(); n++; end
        chk("post_rst_busy_fall", 128'(cyc), 128'(e0 + 2));
        chk("post_rst_hops", 128'(exp_q.size()), 128'(0));
        chk("post_rst_outputs", 128'(outs()), 128'(0));

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
